// File: rtl/tlp_crc.sv
// PCIe LCRC (zlib CRC-32) over one DATA_W-bit TLP word per clock, 1-cycle registered latency.
// Optional TLP_CRC_ECHO_EN: upper output bits echo the registered tlp_in header DWs.
module tlp_crc #(
   parameter int DATA_W = 96
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tlp_in,
   output logic [DATA_W-1:0] crc_out
);

   localparam int CRC_W  = 32;
   localparam int NBYTES = DATA_W / 8;
   localparam int HDR_W  = DATA_W - CRC_W;
   localparam logic [CRC_W-1:0] POLY_REFL = 32'hEDB88320;

   // Byte 0 is the most significant byte; each byte is consumed LSB first.
   // Fully unrolled at elaboration, so this is a pure XOR network.
   function automatic logic [CRC_W-1:0] crc32_word(input logic [DATA_W-1:0] d);
      logic [CRC_W-1:0] c;
      logic             fb;
      c = '1;
      for (int i = 0; i < NBYTES; i++) begin
         for (int j = 0; j < 8; j++) begin
            fb = c[0] ^ d[DATA_W-8-8*i+j];
            c  = {1'b0, c[CRC_W-1:1]} ^ ({CRC_W{fb}} & POLY_REFL);
         end
      end
      return ~c;
   endfunction

   logic [CRC_W-1:0] crc_next;
   logic [CRC_W-1:0] crc_q;

   always_comb begin
      crc_next = crc32_word(tlp_in);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) crc_q <= '0;
      else      crc_q <= crc_next;
   end

`ifdef TLP_CRC_ECHO_EN
   logic [HDR_W-1:0] hdr_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) hdr_q <= '0;
      else      hdr_q <= tlp_in[DATA_W-1:CRC_W];
   end

   assign crc_out = {hdr_q, crc_q};
`else
   assign crc_out = {{HDR_W{1'b0}}, crc_q};
`endif

endmodule

// File: tb/tb_tlp_crc.sv
// Scoreboard bench for tlp_crc: reference CRC-32 model, reset, back-to-back, linearity and echo checks.
module tb_tlp_crc;

   logic        clk;
   logic        rst;
   logic [95:0] tlp_in;
   logic [95:0] crc_out;

   int total = 0;
   int bad   = 0;
   logic [95:0] exp_q[$];

   tlp_crc #(.DATA_W(96)) dut (
      .clk    (clk),
      .rst    (rst),
      .tlp_in (tlp_in),
      .crc_out(crc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] b);
      for (int k = 0; k < 8; k++) rev8[k] = b[7-k];
   endfunction

   function automatic logic [31:0] rev32(input logic [31:0] w);
      for (int k = 0; k < 32; k++) rev32[k] = w[31-k];
   endfunction

   // Non-reflected MSB-first formulation with explicit bit reversal.
   function automatic logic [31:0] crc_ref(input logic [95:0] d);
      logic [31:0] c;
      logic [7:0]  rb;
      logic        fb;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < 12; i++) begin
         rb = rev8(d[95-8*i -: 8]);
         for (int j = 7; j >= 0; j--) begin
            fb = c[31] ^ rb[j];
            c  = {c[30:0], 1'b0};
            if (fb) c = c ^ 32'h04C11DB7;
         end
      end
      return rev32(c) ^ 32'hFFFFFFFF;
   endfunction

   function automatic logic [95:0] exp_out(input logic [95:0] v);
`ifdef TLP_CRC_ECHO_EN
      return {v[95:32], crc_ref(v)};
`else
      return {64'h0, crc_ref(v)};
`endif
   endfunction

   task automatic drive(input logic [95:0] v);
      @(negedge clk);
      tlp_in = v;
      exp_q.push_back(exp_out(v));
   endtask

   always @(posedge clk) begin
      #1;
      if (rst && exp_q.size() > 0) chk("sb", crc_out, exp_q.pop_front());
   end

   task automatic drain();
      for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         chk("drain", 96'(exp_q.size()), 96'h0);
         exp_q.delete();
      end
   endtask

   logic [95:0] vec[5];
   logic [31:0] ca, cb, c0, cab;
   logic [95:0] va, vb;

   task automatic grab(input logic [95:0] v, output logic [31:0] c);
      drive(v);
      @(posedge clk);
      #2;
      c = crc_out[31:0];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      vec[0] = 96'h123456789abcdefffff12345;
      vec[1] = 96'h123456789fffff123456ffff;
      vec[2] = 96'h987654321abcdefffff12345;
      vec[3] = 96'h987654321fffffffff123456;
      vec[4] = 96'h12345678912345ffffff1234;

      // reset held with clock running
      rst    = 1'b0;
      tlp_in = vec[0];
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1 chk("rst_hold", crc_out, 96'h0);
      end
      @(negedge clk);
      rst = 1'b1;

      // golden vectors held 10 cycles each
      foreach (vec[i]) for (int k = 0; k < 10; k++) drive(vec[i]);
      drain();

      // back-to-back
      for (int r = 0; r < 2; r++) foreach (vec[i]) drive(vec[i]);
      drive(96'hFFFFFFFF_FFFFFFFF_FFFFFFFF);
      drive(96'h0);
      drain();

      // asynchronous reset mid-cycle
      @(posedge clk);
      #2 rst = 1'b0;
      #1 chk("rst_async", crc_out, 96'h0);
      @(negedge clk);
      rst = 1'b1;
      drive(vec[3]);
      drive(vec[1]);
      drain();

      // linearity on DUT results
      va = 96'h123456789abcdefffff12345;
      vb = 96'h987654321fffffffff123456;
      grab(va, ca);
      grab(vb, cb);
      grab(96'h0, c0);
      grab(va ^ vb, cab);
      chk("linear", {64'h0, ca ^ cb ^ c0}, {64'h0, cab});
      drain();

      // echo field
      drive(vec[2]);
      @(posedge clk);
      #2;
`ifdef TLP_CRC_ECHO_EN
      chk("echo_hi", {32'h0, crc_out[95:32]}, {32'h0, 64'h987654321abcdeff});
`else
      chk("echo_hi", {32'h0, crc_out[95:32]}, 96'h0);
`endif
      chk("echo_lo", {64'h0, crc_out[31:0]}, {64'h0, crc_ref(vec[2])});
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tlp_crc.md
Name: tlp_crc

Overview:
- Computes the PCIe link CRC (LCRC, CRC-32) over one 96-bit TLP word (3 DWs) per clock.
- Sits in the replay-buffer transmit path, between TLP assembly and the replay buffer/link framer.
- Fully parallel: one result per cycle, registered output, no handshake.

Parameters:
- DATA_W, 96, input word width in bits; must be a multiple of 8.
- CRC_W, 32, CRC width; fixed at 32, not user-tunable.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- tlp_in  input  DATA_W  TLP word; sampled every rising edge.
- crc_out  output  DATA_W  registered result; bits [31:0] are the CRC, bits [DATA_W-1:32] are defined under Optional Feature.

Behaviour:
- Reset: while rst=0, crc_out=0 immediately, without waiting for a clock edge. The first capture happens on the first rising edge after rst rises.
- No enable and no valid input: tlp_in is sampled and processed on every rising edge while rst=1.
- Latency: crc_out reflects the tlp_in sampled at the previous rising edge (1 cycle). It holds that value between edges.
- Each word is an independent 12-byte message. There is no accumulation across cycles.
- CRC algorithm: standard CRC-32 (IEEE 802.3 / zlib).
  - Polynomial 0x04C11DB7, processed reflected as 0xEDB88320.
  - Initial value 0xFFFFFFFF; final XOR 0xFFFFFFFF.
  - Input reflected: each byte LSB first. Output reflected.
- Byte order: byte 0 = tlp_in[95:88] is processed first, then [87:80], down to tlp_in[7:0] last.
- crc_out[31:0] equals zlib crc32() of the byte string tlp_in[95:88], tlp_in[87:80], …, tlp_in[7:0].
- Implementation: purely combinational next-state (unrolled XOR network or loop-generated equations) feeding a single DATA_W-bit register. No multi-cycle iteration.
- Inputs with X/Z give X in the affected CRC bits. No sanitisation is performed.
- Reset asserted mid-stream: output clears asynchronously and no partial state remains. The next word after reset release is computed normally.
- Input changing every cycle: every word yields its own CRC with no dropped or merged words.

Optional Feature:
- Macro: TLP_CRC_ECHO_EN.
- Defined: crc_out[DATA_W-1:32] = registered tlp_in[DATA_W-1:32], captured in the same cycle as the CRC. The output then carries header DW0–DW1 alongside the LCRC of the full word. This field also resets to 0.
- Undefined: crc_out[DATA_W-1:32] is constant 0, and no register bits are spent on it.
- crc_out[31:0] behaviour is identical in both builds.

Test Plan:
- Reset: hold rst=0 with tlp_in=96'h123456789abcdefffff12345 and the clock toggling → crc_out stays 96'h0. Assert rst=0 asynchronously mid-cycle → crc_out goes to 0 before the next edge.
- Golden vectors: after reset, apply in turn 96'h123456789abcdefffff12345, 96'h123456789fffff123456ffff, 96'h987654321abcdefffff12345, 96'h987654321fffffffff123456, 96'h12345678912345ffffff1234, each held 10 cycles → one cycle after each change, crc_out[31:0] equals zlib crc32 of the 12 bytes (MSB byte first). The bench computes this with a reference model.
- Back-to-back: change tlp_in every cycle through the 5 vectors above → each crc_out matches its own input exactly one cycle later, with no skipped or repeated results.
- Linearity check: for equal-length words, CRC(a) ^ CRC(b) ^ CRC(96'h0) == CRC(a^b). Test with a=96'h123456789abcdefffff12345 and b=96'h987654321fffffffff123456. Also apply 96'hFFFFFFFF_FFFFFFFF_FFFFFFFF and confirm it matches the model.
- Echo build:
  - With TLP_CRC_ECHO_EN defined and tlp_in=96'h987654321abcdefffff12345 → crc_out[95:32]=64'h987654321abcdeff.
  - Without the macro → crc_out[95:32]=64'h0.
  - In both builds crc_out[31:0] is unchanged.
